load_store_ctrl: RTL and testbench

Sequencing controller for the core's data-memory port. It accepts one load or store request at a time from the execute stage and checks alignment and `funct3`. It issues a single word-aligned memory transaction with byte strobes, waits for the memory response, then lane-shifts and sign/zero-extends load data (LB/LH/LW/LBU/LHU semantics) before returning it to writeback. It sits between the execute stage and the data-memory interface and owns the only path to data memory.

---
 rtl/load_store_ctrl.sv | 132 +++++++++++++
 tb/tb_load_store_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_ctrl.sv
// rtl/load_store_ctrl.sv - data-memory load/store sequencer with alignment checks and lane handling
// One request in flight: IDLE accepts, REQ issues, WAIT collects the response, RESP reports it.
module load_store_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        req_err;
  logic [3:0]  strb_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign req_ready     = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign rsp_valid     = (state == RESP);

  // Size lives in funct3[1:0]; funct3[2] is only legal as the unsigned flag on B/H loads.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3[1:0])
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (req_funct3[2] && (req_we || req_funct3[1:0] == 2'b10))
      req_err = 1'b1;
  end

  always_comb begin
    strb_n  = 4'b1111;
    wdata_n = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        strb_n  = 4'b0001 << req_addr[1:0];
        wdata_n = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb_n  = 4'b0011 << req_addr[1:0];
        wdata_n = {2{req_wdata[15:0]}};
      end
      default: begin
        strb_n  = 4'b1111;
        wdata_n = req_wdata;
      end
    endcase
    if (!req_we)
      strb_n = 4'b0000;
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = shifted;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wstrb <= 4'd0;
      mem_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_rd    <= 5'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q  <= req_funct3;
            off_q     <= req_addr[1:0];
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wstrb <= strb_n;
            mem_wdata <= wdata_n;
            rsp_rd    <= req_rd;
            rsp_err   <= req_err;
            rsp_rdata <= 32'd0;
            state     <= req_err ? RESP : REQ;
          end
        end
        REQ: begin
          if (mem_req_ready)
            state <= WAIT;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (!mem_we)
              rsp_rdata <= load_data;
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_ctrl.sv
// tb/tb_load_store_ctrl.sv - directed self-checking bench for load_store_ctrl
// A task plays the memory side; each transaction's results are compared against hand-computed values.
module tb_load_store_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [4:0]  r_rd;
  logic [3:0]  r_wstrb;
  logic        r_err, r_we, r_saw, r_after;
  int          r_lat, r_unstable;

  load_store_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latency counts clock edges from the accepting edge to the edge that raises rsp_valid.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] word,
                     input int stall, input int dly);
    int  phase, wait_n, n;
    bit  got;
    got = 0; phase = 0; wait_n = 0; n = 0;
    r_saw = 0; r_unstable = 0; r_lat = -1;
    r_rdata = 'x; r_err = 1'bx; r_rd = 'x;
    r_we = 1'b0; r_addr = 32'd0; r_wstrb = 4'd0; r_wdata = 32'd0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5555_5555;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (rsp_valid) begin
        got = 1; r_lat = k;
        r_rdata = rsp_rdata; r_err = rsp_err; r_rd = rsp_rd;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        case (phase)
          0: if (mem_req_valid) begin
            if (!r_saw) begin
              r_saw = 1; r_we = mem_we; r_addr = mem_addr;
              r_wstrb = mem_wstrb; r_wdata = mem_wdata;
            end else if ({mem_we, mem_addr, mem_wstrb, mem_wdata} !== {r_we, r_addr, r_wstrb, r_wdata}) begin
              r_unstable++;
            end
            if (n >= stall) begin
              mem_req_ready = 1'b1;
              phase = 1;
            end
            n++;
          end
          1: if (wait_n >= dly) begin
            mem_rsp_valid = 1'b1;
            mem_rdata = word;
            phase = 2;
          end else begin
            wait_n++;
          end
          default: ;
        endcase
        @(posedge clk);
        @(negedge clk);
      end
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    r_after = rsp_valid;
  endtask

  task automatic check_load(input string tag, input logic [31:0] exp_data,
                            input logic [31:0] exp_addr, input logic [4:0] exp_rd);
    check({tag, " rdata"}, r_rdata, exp_data);
    check({tag, " err"}, r_err, 1'b0);
    check({tag, " rd"}, r_rd, exp_rd);
    check({tag, " mem"}, {r_saw, r_we, r_addr, r_wstrb}, {1'b1, 1'b0, exp_addr, 4'b0000});
    check({tag, " latency"}, r_lat, 3);
    check({tag, " single rsp"}, r_after, 1'b0);
  endtask

  task automatic check_store(input string tag, input logic [31:0] exp_addr,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    check({tag, " mem"}, {r_saw, r_we, r_addr, r_wstrb, r_wdata},
          {1'b1, 1'b1, exp_addr, exp_strb, exp_wdata});
    check({tag, " rsp"}, {r_err, r_rdata}, {1'b0, 32'd0});
    check({tag, " latency"}, r_lat, 3);
  endtask

  logic        e_we   [4];
  logic [2:0]  e_f3   [4];
  logic [31:0] e_addr [4];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs",
          {req_ready, mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata, rsp_valid, rsp_rdata, rsp_rd, rsp_err},
          {1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0});
    rst_n = 1'b1;

    run(1'b0, 3'b000, 32'h100, 32'd0, 5'd1, 32'h3456_789A, 0, 0);
    check_load("LB 100", 32'hFFFF_FF9A, 32'h100, 5'd1);
    run(1'b0, 3'b100, 32'h103, 32'd0, 5'd2, 32'h3456_789A, 0, 0);
    check_load("LBU 103", 32'h0000_0034, 32'h100, 5'd2);
    run(1'b0, 3'b001, 32'h100, 32'd0, 5'd3, 32'h3456_789A, 0, 0);
    check_load("LH 100", 32'h0000_789A, 32'h100, 5'd3);
    run(1'b0, 3'b101, 32'h102, 32'd0, 5'd4, 32'h3456_789A, 0, 0);
    check_load("LHU 102", 32'h0000_3456, 32'h100, 5'd4);
    run(1'b0, 3'b010, 32'h100, 32'd0, 5'd5, 32'h3456_789A, 0, 0);
    check_load("LW 100", 32'h3456_789A, 32'h100, 5'd5);
    run(1'b0, 3'b001, 32'h202, 32'd0, 5'd17, 32'h80F0_F0F0, 0, 0);
    check_load("LH 202", 32'hFFFF_80F0, 32'h200, 5'd17);
    run(1'b0, 3'b000, 32'h203, 32'd0, 5'd9, 32'h80F0_F0F0, 0, 0);
    check_load("LB 203", 32'hFFFF_FF80, 32'h200, 5'd9);

    run(1'b1, 3'b000, 32'h101, 32'h0000_00AB, 5'd6, 32'd0, 0, 0);
    check_store("SB 101", 32'h100, 4'b0010, 32'hABAB_ABAB);
    run(1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 5'd7, 32'd0, 0, 0);
    check_store("SH 102", 32'h100, 4'b1100, 32'hBEEF_BEEF);
    run(1'b1, 3'b010, 32'h104, 32'h1234_5678, 5'd8, 32'd0, 0, 0);
    check_store("SW 104", 32'h104, 4'b1111, 32'h1234_5678);

    e_we[0] = 1'b0; e_f3[0] = 3'b010; e_addr[0] = 32'h102;
    e_we[1] = 1'b0; e_f3[1] = 3'b001; e_addr[1] = 32'h101;
    e_we[2] = 1'b0; e_f3[2] = 3'b011; e_addr[2] = 32'h100;
    e_we[3] = 1'b1; e_f3[3] = 3'b010; e_addr[3] = 32'h106;
    for (int i = 0; i < 4; i++) begin
      run(e_we[i], e_f3[i], e_addr[i], 32'hFFFF_FFFF, 5'd11, 32'h3456_789A, 0, 0);
      check($sformatf("error %0d rsp", i), {r_err, r_rdata, r_rd}, {1'b1, 32'd0, 5'd11});
      check($sformatf("error %0d latency", i), r_lat, 1);
      check($sformatf("error %0d no mem req", i), r_saw, 1'b0);
    end
    run(1'b1, 3'b100, 32'h100, 32'd0, 5'd12, 32'd0, 0, 0);
    check("store f3 100 error", {r_err, r_lat, r_saw}, {1'b1, 32'd1, 1'b0});

    run(1'b0, 3'b010, 32'h100, 32'd0, 5'd13, 32'h3456_789A, 3, 1);
    check("stall rdata", {r_err, r_rdata, r_rd}, {1'b0, 32'h3456_789A, 5'd13});
    check("stall mem stable", r_unstable, 0);
    check("stall latency", r_lat, 7);
    check("stall single rsp", r_after, 1'b0);

    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("spurious rsp 1", {rsp_valid, req_ready, mem_req_valid}, 3'b010);
    @(posedge clk);
    @(negedge clk);
    check("spurious rsp 2", {rsp_valid, req_ready, mem_req_valid}, 3'b010);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_rd = 5'd20;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst-wait issue", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rst-wait in WAIT", {mem_req_valid, rsp_valid, req_ready}, 3'b000);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst-wait after reset", {req_ready, mem_req_valid, rsp_valid, rsp_err, rsp_rdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h3456_789A;
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("rst-wait late rsp 1", {rsp_valid, req_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    check("rst-wait late rsp 2", {rsp_valid, req_ready}, 2'b01);

    run(1'b0, 3'b000, 32'h100, 32'd0, 5'd21, 32'h3456_789A, 0, 0);
    check_load("LB after reset", 32'hFFFF_FF9A, 32'h100, 5'd21);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
